// File: rtl/rr_arb_pkg.sv
// ============================================================================
// rr_arb_pkg : shared constants, FSM state type and tag-layout helpers for rr_arb_n
// Rev 1.0
// ============================================================================
`default_nettype none

package rr_arb_pkg;

    localparam int PCIE_TAG_W = 8;
    localparam int ADDR_W     = 64;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [PCIE_TAG_W-1:0] field_mask(input int bits);
        logic [15:0] m;
        m = (16'd1 << bits) - 16'd1;
        return m[PCIE_TAG_W-1:0];
    endfunction

    // Tag layout: channel field sits at offset CTAG, width CHW; local tag below it.
    function automatic logic [PCIE_TAG_W-1:0] tag_pack(input int chw, input int ctag,
                                                       input logic [PCIE_TAG_W-1:0] ch,
                                                       input logic [PCIE_TAG_W-1:0] ltag);
        return ((ch & field_mask(chw)) << ctag) | (ltag & field_mask(ctag));
    endfunction

    function automatic logic [PCIE_TAG_W-1:0] tag_chan(input int chw, input int ctag,
                                                       input logic [PCIE_TAG_W-1:0] tag);
        return (tag >> ctag) & field_mask(chw);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_credit.sv
// ============================================================================
// rr_credit : per-channel outstanding-read credit counter, resets to MAXOUT
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_credit
    import rr_arb_pkg::*;
#(
    parameter int MAXOUT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic take_i,
    input  logic give_i,
    output logic full_o,
    output logic empty_o,
    output logic err_o
);

    localparam int CW = clog2(MAXOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign full_o  = (cnt_q == CW'(MAXOUT));
    assign empty_o = (cnt_q == '0);

    // Simultaneous take and give cancel out.
    always_comb begin
        cnt_d = cnt_q;
        err_o = 1'b0;
        if (take_i && !give_i && !empty_o) begin
            cnt_d = cnt_q - 1'b1;
        end else if (give_i && !take_i) begin
            if (full_o) err_o = 1'b1;
            else        cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= CW'(MAXOUT);
        else        cnt_q <= cnt_d;
    end

endmodule

`default_nettype wire

// File: rtl/rr_arb_n.sv
// ============================================================================
// rr_arb_n : round-robin read-request arbiter with per-channel credits.
// Optional macro RR_ARB_N_STATS_EN adds per-channel grant counters. Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb_n
    import rr_arb_pkg::*;
#(
    parameter int NCH    = 8,
    parameter int CHW    = 3,
    parameter int CTAG   = 3,
    parameter int AMIN   = 3,
    parameter int MAXOUT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NCH-1:0]          rri_valid,
    output logic [NCH-1:0]          rri_ready,
    input  logic [NCH*ADDR_W-1:0]   rri_addr,
    input  logic [NCH*CTAG-1:0]     rri_tag,
    output logic                    rro_valid,
    input  logic                    rro_ready,
    output logic [ADDR_W-1:0]       rro_addr,
    output logic [PCIE_TAG_W-1:0]   rro_tag,
    input  logic                    done_valid,
    input  logic [PCIE_TAG_W-1:0]   done_tag,
    output logic                    credit_err,
    input  logic [CHW-1:0]          stat_sel,
    output logic [31:0]             stat_count
);

    arb_state_e               state_q;
    logic [CHW-1:0]           ptr_q;
    logic [CHW-1:0]           gnt_q;
    logic                     rro_valid_q;
    logic [ADDR_W-1:0]        rro_addr_q;
    logic [PCIE_TAG_W-1:0]    rro_tag_q;
    logic                     credit_err_q;

    logic [NCH-1:0]           w_elig;
    logic [NCH-1:0]           w_empty;
    logic [NCH-1:0]           w_unused_full;
    logic [NCH-1:0]           w_take;
    logic [NCH-1:0]           w_give;
    logic [NCH-1:0]           w_cerr;
    logic                     w_found;
    logic [CHW-1:0]           w_grant;
    logic                     w_hs;
    logic [ADDR_W-1:0]        w_addr;
    logic [CTAG-1:0]          w_ltag;
    logic [PCIE_TAG_W-1:0]    w_done_ch;
    logic                     w_done_bad;

    assign w_elig     = rri_valid & ~w_empty;
    assign w_hs       = (state_q == ST_OFFER) && rro_ready;
    assign w_done_ch  = tag_chan(CHW, CTAG, done_tag);
    assign w_done_bad = (w_done_ch >= PCIE_TAG_W'(NCH));

    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_grant = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_grant = CHW'(idx);
            end
        end
    end

    assign w_addr = rri_addr[w_grant*ADDR_W +: ADDR_W];
    assign w_ltag = rri_tag[w_grant*CTAG +: CTAG];

    // Pop pulse is combinational so the source sees it in the search cycle.
    assign rri_ready = (reset && (state_q == ST_IDLE) && w_found)
                     ? ({{(NCH-1){1'b0}}, 1'b1} << w_grant) : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            rro_valid_q <= 1'b0;
            rro_addr_q  <= '0;
            rro_tag_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_found) begin
                        gnt_q       <= w_grant;
                        rro_addr_q  <= w_addr & ~((64'd1 << AMIN) - 64'd1);
                        rro_tag_q   <= tag_pack(CHW, CTAG, PCIE_TAG_W'(w_grant),
                                                PCIE_TAG_W'(w_ltag));
                        rro_valid_q <= 1'b1;
                        state_q     <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (rro_ready) begin
                        ptr_q       <= (gnt_q == CHW'(NCH - 1)) ? '0 : gnt_q + 1'b1;
                        rro_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rro_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_credit
            assign w_take[c] = w_hs && (gnt_q == CHW'(c));
            assign w_give[c] = done_valid && (w_done_ch == PCIE_TAG_W'(c));

            rr_credit #(
                .MAXOUT (MAXOUT)
            ) u_credit (
                .clock   (clock),
                .reset   (reset),
                .take_i  (w_take[c]),
                .give_i  (w_give[c]),
                .full_o  (w_unused_full[c]),
                .empty_o (w_empty[c]),
                .err_o   (w_cerr[c])
            );
        end
    endgenerate

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                   credit_err_q <= 1'b0;
        else if ((|w_cerr) || (done_valid && w_done_bad)) credit_err_q <= 1'b1;
    end

    assign rro_valid  = rro_valid_q;
    assign rro_addr   = rro_addr_q;
    assign rro_tag    = rro_tag_q;
    assign credit_err = credit_err_q;

`ifdef RR_ARB_N_STATS_EN
    logic [31:0] stat_q [NCH];
    logic [31:0] stat_count_q;
    logic [31:0] stat_sel_d;

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_stat
            always_ff @(posedge clock or negedge reset) begin
                if (!reset)         stat_q[c] <= '0;
                else if (w_take[c]) stat_q[c] <= stat_q[c] + 32'd1;
            end
        end
    endgenerate

    always_comb begin
        stat_sel_d = '0;
        for (int c = 0; c < NCH; c++) begin
            if (32'(stat_sel) == 32'(c)) stat_sel_d = stat_q[c];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) stat_count_q <= '0;
        else        stat_count_q <= stat_sel_d;
    end

    assign stat_count = stat_count_q;
`else
    logic w_unused_stat_sel;
    assign w_unused_stat_sel = ^stat_sel;
    assign stat_count        = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_n.sv
// ============================================================================
// tb_rr_arb_n : directed self-checking bench for rr_arb_n
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rr_arb_n;

    localparam int NCH    = 8;
    localparam int CHW    = 3;
    localparam int CTAG   = 3;
    localparam int AMIN   = 3;
    localparam int MAXOUT = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NCH-1:0]       rri_valid;
    logic [NCH-1:0]       rri_ready;
    logic [NCH*64-1:0]    rri_addr;
    logic [NCH*CTAG-1:0]  rri_tag;
    logic                 rro_valid;
    logic                 rro_ready;
    logic [63:0]          rro_addr;
    logic [7:0]           rro_tag;
    logic                 done_valid;
    logic [7:0]           done_tag;
    logic                 credit_err;
    logic [CHW-1:0]       stat_sel;
    logic [31:0]          stat_count;

    // Second instance with a wider channel field to reach channel numbers >= NCH.
    logic [NCH-1:0]       rri_ready9;
    logic                 rro_valid9;
    logic [63:0]          rro_addr9;
    logic [7:0]           rro_tag9;
    logic                 done_valid9;
    logic [7:0]           done_tag9;
    logic                 credit_err9;
    logic [31:0]          stat_count9;

    int n_tests = 0;
    int n_fail  = 0;

    rr_arb_n #(.NCH(NCH), .CHW(CHW), .CTAG(CTAG), .AMIN(AMIN), .MAXOUT(MAXOUT)) dut (
        .clock      (clock),
        .reset      (reset),
        .rri_valid  (rri_valid),
        .rri_ready  (rri_ready),
        .rri_addr   (rri_addr),
        .rri_tag    (rri_tag),
        .rro_valid  (rro_valid),
        .rro_ready  (rro_ready),
        .rro_addr   (rro_addr),
        .rro_tag    (rro_tag),
        .done_valid (done_valid),
        .done_tag   (done_tag),
        .credit_err (credit_err),
        .stat_sel   (stat_sel),
        .stat_count (stat_count)
    );

    rr_arb_n #(.NCH(NCH), .CHW(4), .CTAG(CTAG), .AMIN(AMIN), .MAXOUT(MAXOUT)) dut9 (
        .clock      (clock),
        .reset      (reset),
        .rri_valid  ({NCH{1'b0}}),
        .rri_ready  (rri_ready9),
        .rri_addr   ({(NCH*64){1'b0}}),
        .rri_tag    ({(NCH*CTAG){1'b0}}),
        .rro_valid  (rro_valid9),
        .rro_ready  (1'b0),
        .rro_addr   (rro_addr9),
        .rro_tag    (rro_tag9),
        .done_valid (done_valid9),
        .done_tag   (done_tag9),
        .credit_err (credit_err9),
        .stat_sel   (4'd0),
        .stat_count (stat_count9)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rri_valid   = '0;
        rro_ready   = 1'b0;
        done_valid  = 1'b0;
        done_valid9 = 1'b0;
        reset       = 1'b0;
        tick();
        reset       = 1'b1;
        tick();
    endtask

    task automatic count_grants(input int cycles, output int grants);
        grants = 0;
        for (int i = 0; i < cycles; i++) begin
            if (rro_valid === 1'b1) grants++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        rri_valid = '1;
        rro_ready = 1'b0;
        tick();
        tick();
        n_tests++; if (rro_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rro_valid: got %0h expected 0", rro_valid); end
        n_tests++; if (rri_ready !== 8'h00) begin n_fail++; $display("FAIL reset_rri_ready: got %0h expected 0", rri_ready); end
        n_tests++; if (rro_addr !== 64'h0) begin n_fail++; $display("FAIL reset_rro_addr: got %0h expected 0", rro_addr); end
        n_tests++; if (rro_tag !== 8'h00) begin n_fail++; $display("FAIL reset_rro_tag: got %0h expected 0", rro_tag); end
        n_tests++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL reset_credit_err: got %0h expected 0", credit_err); end
        n_tests++; if (stat_count !== 32'h0) begin n_fail++; $display("FAIL reset_stat_count: got %0h expected 0", stat_count); end
        rri_valid = '0;
        reset     = 1'b1;
        tick();
    endtask

    task automatic test_fairness();
        int c;
        do_reset();
        rri_valid = '1;
        rro_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            c = k % NCH;
            #1;
            n_tests++; if (rri_ready !== 8'(1 << c)) begin n_fail++; $display("FAIL fair_grant k=%0d: got %0h expected %0h", k, rri_ready, 8'(1 << c)); end
            tick();
            n_tests++; if (rro_valid !== 1'b1) begin n_fail++; $display("FAIL fair_valid k=%0d: got %0h expected 1", k, rro_valid); end
            n_tests++; if (rri_ready !== 8'h00) begin n_fail++; $display("FAIL fair_pulse k=%0d: got %0h expected 0", k, rri_ready); end
            n_tests++; if (rro_tag !== 8'((c << 3) | c)) begin n_fail++; $display("FAIL fair_tag k=%0d: got %0h expected %0h", k, rro_tag, 8'((c << 3) | c)); end
            n_tests++; if (rro_addr !== 64'(c) * 64'h1000) begin n_fail++; $display("FAIL fair_addr k=%0d: got %0h expected %0h", k, rro_addr, 64'(c) * 64'h1000); end
            done_valid = 1'b1;
            done_tag   = 8'(c << 3);
            tick();
            done_valid = 1'b0;
        end
        n_tests++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL fair_credit_err: got %0h expected 0", credit_err); end
    endtask

    task automatic test_backpressure();
        do_reset();
        rri_addr[3*64 +: 64] = 64'h0000_0001_2345_678F;
        rri_tag[3*CTAG +: CTAG] = 3'd5;
        rri_valid = 8'h08;
        rro_ready = 1'b0;
        #1;
        n_tests++; if (rri_ready !== 8'h08) begin n_fail++; $display("FAIL bp_grant: got %0h expected 08", rri_ready); end
        tick();
        for (int i = 0; i < 10; i++) begin
            n_tests++; if (rro_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold i=%0d: got %0h expected 1", i, rro_valid); end
            n_tests++; if (rri_ready !== 8'h00) begin n_fail++; $display("FAIL bp_no_pop i=%0d: got %0h expected 0", i, rri_ready); end
            n_tests++; if (rro_addr !== 64'h0000_0001_2345_6788) begin n_fail++; $display("FAIL bp_addr i=%0d: got %0h expected 123456788", i, rro_addr); end
            n_tests++; if (rro_tag !== 8'h1D) begin n_fail++; $display("FAIL bp_tag i=%0d: got %0h expected 1d", i, rro_tag); end
            tick();
        end
        rro_ready = 1'b1;
        rri_valid = '0;
        tick();
        n_tests++; if (rro_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %0h expected 0", rro_valid); end
        rro_ready = 1'b0;
    endtask

    task automatic test_credits();
        int grants;
        do_reset();
        rri_valid = 8'h01;
        rro_ready = 1'b1;
        count_grants(20, grants);
        n_tests++; if (grants !== 4) begin n_fail++; $display("FAIL credit_limit: got %0d grants expected 4", grants); end
        done_valid = 1'b1;
        done_tag   = 8'h02;
        tick();
        done_valid = 1'b0;
        count_grants(20, grants);
        n_tests++; if (grants !== 1) begin n_fail++; $display("FAIL credit_return: got %0d grants expected 1", grants); end
        n_tests++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL credit_no_err: got %0h expected 0", credit_err); end
    endtask

    task automatic test_credit_edges();
        int grants;
        do_reset();
        rri_valid = 8'h04;
        rro_ready = 1'b0;
        tick();
        rro_ready  = 1'b1;
        done_valid = 1'b1;
        done_tag   = 8'h10;
        tick();
        done_valid = 1'b0;
        count_grants(20, grants);
        n_tests++; if (grants !== 4) begin n_fail++; $display("FAIL same_cycle_credit: got %0d grants expected 4", grants); end

        do_reset();
        done_valid = 1'b1;
        done_tag   = 8'h28;
        tick();
        done_valid = 1'b0;
        n_tests++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL err_full: got %0h expected 1", credit_err); end
        tick(); tick(); tick();
        n_tests++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %0h expected 1", credit_err); end

        n_tests++; if (credit_err9 !== 1'b0) begin n_fail++; $display("FAIL err_range_pre: got %0h expected 0", credit_err9); end
        done_valid9 = 1'b1;
        done_tag9   = 8'h48;
        tick();
        done_valid9 = 1'b0;
        n_tests++; if (credit_err9 !== 1'b1) begin n_fail++; $display("FAIL err_range: got %0h expected 1", credit_err9); end
    endtask

    task automatic test_reset_mid_offer();
        int grants;
        do_reset();
        rri_valid = 8'h20;
        rro_ready = 1'b0;
        tick();
        n_tests++; if (rro_valid !== 1'b1) begin n_fail++; $display("FAIL mid_offer_valid: got %0h expected 1", rro_valid); end
        #2;
        reset = 1'b0;
        #1;
        n_tests++; if (rro_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset: got %0h expected 0", rro_valid); end
        n_tests++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL async_reset_err: got %0h expected 0", credit_err); end
        tick();
        reset     = 1'b1;
        rri_valid = 8'hFF;
        #1;
        n_tests++; if (rri_ready !== 8'h01) begin n_fail++; $display("FAIL post_reset_grant: got %0h expected 01", rri_ready); end
        rri_valid = 8'h01;
        rro_ready = 1'b1;
        count_grants(20, grants);
        n_tests++; if (grants !== 4) begin n_fail++; $display("FAIL post_reset_credit: got %0d grants expected 4", grants); end
    endtask

    task automatic test_stats();
        do_reset();
        rri_valid = 8'h02;
        rro_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        rri_valid = '0;
        stat_sel  = 3'd1;
        tick();
`ifdef RR_ARB_N_STATS_EN
        n_tests++; if (stat_count !== 32'd3) begin n_fail++; $display("FAIL stat_ch1: got %0d expected 3", stat_count); end
        stat_sel = 3'd2;
        tick();
        n_tests++; if (stat_count !== 32'd0) begin n_fail++; $display("FAIL stat_ch2: got %0d expected 0", stat_count); end
`else
        n_tests++; if (stat_count !== 32'd0) begin n_fail++; $display("FAIL stat_disabled: got %0d expected 0", stat_count); end
`endif
    endtask

    initial begin
        reset       = 1'b0;
        rri_valid   = '0;
        rro_ready   = 1'b0;
        done_valid  = 1'b0;
        done_tag    = '0;
        done_valid9 = 1'b0;
        done_tag9   = '0;
        stat_sel    = '0;
        for (int c = 0; c < NCH; c++) begin
            rri_addr[c*64 +: 64]    = 64'(c) * 64'h1000 + 64'h7;
            rri_tag[c*CTAG +: CTAG] = 3'(c);
        end

        test_reset();
        test_fairness();
        test_backpressure();
        test_credits();
        test_credit_edges();
        test_reset_mid_offer();
        test_stats();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
